// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer sitting beside decode.
// Handles load-use bubbles, redirect flush windows with a branch shadow,
// and a global freeze (HLT) while data memory is busy, with a timeout flag.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic        CLK,
   input  logic        RESN,
   input  logic        MEM_BUSY,
   input  logic        BR_TAKEN,
   input  logic        EX_REDIRECT,
   input  logic [31:0] IF_ID_inst,
   input  logic [31:0] ID_EX_inst,
   input  logic [4:0]  ID_EX_rd,
   output logic        HLT,
   output logic        STALL_IF,
   output logic        FLUSH_ID,
   output logic        FLUSH_IF,
   output logic        BR_SHADOW,
   output logic        ERR
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] LU_CNT,
   output logic [31:0] FLUSH_CNT,
   output logic [31:0] HLT_CNT
`endif
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BCC   = 7'b1100011;
   localparam logic [6:0] OP_SCC   = 7'b0100011;
   localparam logic [6:0] OP_RCC   = 7'b0110011;

   localparam logic [3:0] FC_RELOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [7:0] TIMEOUT   = 8'(BUSY_TIMEOUT);

   typedef enum logic [1:0] {RUN, REDIR, MWAIT} state_t;

   state_t      state, state_nxt, saved, saved_nxt, eff;
   logic [3:0]  fcnt, fcnt_nxt;
   logic [7:0]  bcnt, bcnt_nxt;
   logic        err_q, err_nxt;
   logic        lu, rd_req, lu_stall, redir_evt;
   logic [6:0]  if_op;
   logic [4:0]  rs1, rs2;
   logic        uses_rs1, uses_rs2;
   logic        unused_bits;

   assign if_op       = IF_ID_inst[6:0];
   assign rs1         = IF_ID_inst[19:15];
   assign rs2         = IF_ID_inst[24:20];
   assign unused_bits = ^{IF_ID_inst[31:25], IF_ID_inst[14:7], ID_EX_inst[31:7]};

   // Load-use detection against the instruction in decode
   always_comb begin
      uses_rs1 = !(if_op == OP_LUI || if_op == OP_AUIPC || if_op == OP_JAL);
      uses_rs2 = (if_op == OP_BCC || if_op == OP_SCC || if_op == OP_RCC);
      lu = (ID_EX_inst[6:0] == OP_LOAD) && (ID_EX_rd != 5'd0) &&
           (((ID_EX_rd == rs1) && uses_rs1) || ((ID_EX_rd == rs2) && uses_rs2));
      rd_req = BR_TAKEN | EX_REDIRECT;
   end

   // Next-state and output decode; a memory stall overrides everything else
   always_comb begin
      HLT       = 1'b0;
      STALL_IF  = 1'b0;
      FLUSH_ID  = 1'b0;
      FLUSH_IF  = 1'b0;
      BR_SHADOW = 1'b0;
      lu_stall  = 1'b0;
      redir_evt = 1'b0;
      state_nxt = state;
      saved_nxt = saved;
      fcnt_nxt  = fcnt;
      bcnt_nxt  = bcnt;
      err_nxt   = err_q;
      // leaving MWAIT resumes the frozen state in the same cycle
      eff = (state == MWAIT) ? saved : state;
      if (MEM_BUSY) begin
         HLT = 1'b1;
         if (state != MWAIT) begin
            saved_nxt = state;
            state_nxt = MWAIT;
         end else begin
            if (bcnt != 8'hFF) bcnt_nxt = bcnt + 8'd1;
            if (bcnt_nxt >= TIMEOUT) err_nxt = 1'b1;
         end
      end else begin
         bcnt_nxt  = 8'd0;
         state_nxt = eff;
         case (eff)
            REDIR: begin
               FLUSH_IF  = 1'b1;
               BR_SHADOW = 1'b1;
               if (fcnt <= 4'd1) begin
                  state_nxt = RUN;
                  fcnt_nxt  = 4'd0;
               end else begin
                  fcnt_nxt = fcnt - 4'd1;
               end
            end
            default: begin
               if (rd_req) begin
                  // redirect wins over a coincident load-use
                  FLUSH_IF  = 1'b1;
                  FLUSH_ID  = EX_REDIRECT | lu;
                  redir_evt = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_nxt = REDIR;
                     fcnt_nxt  = FC_RELOAD;
                  end
               end else if (lu) begin
                  STALL_IF = 1'b1;
                  FLUSH_ID = 1'b1;
                  lu_stall = 1'b1;
               end
            end
         endcase
      end
      ERR = err_nxt;
   end

   // State, saved context and counters
   always_ff @(posedge CLK or negedge RESN) begin
      if (!RESN) begin
         state <= RUN;
         saved <= RUN;
         fcnt  <= 4'd0;
         bcnt  <= 8'd0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         saved <= saved_nxt;
         fcnt  <= fcnt_nxt;
         bcnt  <= bcnt_nxt;
         err_q <= err_nxt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Free-running event counters, wrapping modulo 2^32
   always_ff @(posedge CLK or negedge RESN) begin
      if (!RESN) begin
         LU_CNT    <= 32'd0;
         FLUSH_CNT <= 32'd0;
         HLT_CNT   <= 32'd0;
      end else begin
         if (lu_stall)  LU_CNT    <= LU_CNT + 32'd1;
         if (redir_evt) FLUSH_CNT <= FLUSH_CNT + 32'd1;
         if (HLT)       HLT_CNT   <= HLT_CNT + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// each cycle checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int FC = 2;
   localparam int TO = 15;

   localparam logic [6:0] LOAD = 7'b0000011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                          JAL = 7'b1101111, BCC = 7'b1100011, SCC = 7'b0100011,
                          RCC = 7'b0110011, ICC = 7'b0010011;

   logic        CLK = 1'b0, RESN = 1'b0, MEM_BUSY = 1'b0, BR_TAKEN = 1'b0, EX_REDIRECT = 1'b0;
   logic [31:0] IF_ID_inst = '0, ID_EX_inst = '0;
   logic [4:0]  ID_EX_rd = '0;
   logic        HLT, STALL_IF, FLUSH_ID, FLUSH_IF, BR_SHADOW, ERR;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] LU_CNT, FLUSH_CNT, HLT_CNT;
`endif

   pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .BUSY_TIMEOUT(TO)) dut (
      .CLK(CLK), .RESN(RESN), .MEM_BUSY(MEM_BUSY), .BR_TAKEN(BR_TAKEN),
      .EX_REDIRECT(EX_REDIRECT), .IF_ID_inst(IF_ID_inst), .ID_EX_inst(ID_EX_inst),
      .ID_EX_rd(ID_EX_rd), .HLT(HLT), .STALL_IF(STALL_IF), .FLUSH_ID(FLUSH_ID),
      .FLUSH_IF(FLUSH_IF), .BR_SHADOW(BR_SHADOW), .ERR(ERR)
`ifdef HAZARD_PERF_CNT_EN
      , .LU_CNT(LU_CNT), .FLUSH_CNT(FLUSH_CNT), .HLT_CNT(HLT_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   int n_tests = 0, n_fail = 0;
   // model: remaining shadow cycles, consecutive busy cycles, sticky error
   int flush_left = 0, busy_run = 0;
   bit err_s = 0;
   int m_lu = 0, m_flush = 0, m_hlt = 0;

   // output vector: {HLT, STALL_IF, FLUSH_ID, FLUSH_IF, BR_SHADOW, ERR}
   function automatic logic [5:0] obs_vec();
      return {HLT, STALL_IF, FLUSH_ID, FLUSH_IF, BR_SHADOW, ERR};
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] r1, input logic [4:0] r2);
      return {7'b0, r2, r1, 3'b0, rd, op};
   endfunction

   task automatic chk(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      obs = obs_vec();
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      flush_left = 0; busy_run = 0; err_s = 0;
      m_lu = 0; m_flush = 0; m_hlt = 0;
   endtask

   // one clock cycle: apply inputs, compare with the model, advance the model
   task automatic step(input string tag, input bit busy, input bit br, input bit exr,
                       input logic [31:0] ifid, input logic [31:0] idex, input logic [4:0] rd);
      logic [5:0] exp;
      bit lu, ld, u1, u2;
      logic [6:0] op;
      @(negedge CLK);
      MEM_BUSY = busy; BR_TAKEN = br; EX_REDIRECT = exr;
      IF_ID_inst = ifid; ID_EX_inst = idex; ID_EX_rd = rd;
      #1;
      exp = '0;
      if (busy) begin
         exp[5] = 1'b1;
         busy_run++;
         m_hlt++;
         if (busy_run - 1 >= TO) err_s = 1;
      end else begin
         busy_run = 0;
         if (flush_left > 0) begin
            exp[2] = 1'b1; exp[1] = 1'b1;
            flush_left--;
         end else begin
            op = ifid[6:0];
            ld = (idex[6:0] == LOAD) && (rd != 0);
            u1 = !(op == LUI || op == AUIPC || op == JAL);
            u2 = (op == BCC || op == SCC || op == RCC);
            lu = ld && ((rd == ifid[19:15] && u1) || (rd == ifid[24:20] && u2));
            if (br || exr) begin
               exp[2] = 1'b1;
               exp[3] = exr | lu;
               flush_left = FC - 1;
               m_flush++;
            end else if (lu) begin
               exp[4] = 1'b1; exp[3] = 1'b1;
               m_lu++;
            end
         end
      end
      exp[0] = err_s;
      chk(tag, exp);
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, 0, '0, '0, '0);
   endtask

   task automatic reset_now(input string tag);
      @(negedge CLK);
      #1 RESN = 1'b0;
      MEM_BUSY = 0; BR_TAKEN = 0; EX_REDIRECT = 0;
      #1;
      model_reset();
      chk(tag, 6'b000000);
      @(negedge CLK);
      RESN = 1'b1;
   endtask

   initial begin
      int burst;
      logic [6:0] ops [8];
      logic [6:0] iop;
      logic [4:0] rrd;
      ops = '{LUI, AUIPC, JAL, BCC, SCC, RCC, ICC, LOAD};

      // reset state
      #2;
      model_reset();
      chk("reset", 6'b000000);
      @(negedge CLK);
      RESN = 1'b1;

      // load-use on rs1, then bubble gone, rd=0 never stalls
      step("lu_rs1", 0, 0, 0, mk(RCC, 6, 5, 1), mk(LOAD, 5, 2, 0), 5);
      chk("lu_rs1_exp", 6'b011000);
      step("lu_after", 0, 0, 0, mk(RCC, 6, 5, 1), '0, 0);
      chk("lu_after_exp", 6'b000000);
      step("lu_rd0", 0, 0, 0, mk(RCC, 6, 0, 0), mk(LOAD, 0, 2, 0), 0);
      chk("lu_rd0_exp", 6'b000000);

      // store rs2 match stalls; LUI with matching rs1 field does not
      step("lu_sw_rs2", 0, 0, 0, mk(SCC, 0, 1, 5), mk(LOAD, 5, 2, 0), 5);
      chk("lu_sw_rs2_exp", 6'b011000);
      step("lu_lui", 0, 0, 0, mk(LUI, 5, 5, 5), mk(LOAD, 5, 2, 0), 5);
      chk("lu_lui_exp", 6'b000000);
      step("lu_addi_rs2", 0, 0, 0, mk(ICC, 7, 1, 5), mk(LOAD, 5, 2, 0), 5);
      chk("lu_addi_rs2_exp", 6'b000000);

      // branch flush window
      step("br_det", 0, 1, 0, '0, '0, 0);
      chk("br_det_exp", 6'b000100);
      idle("br_redir");
      chk("br_redir_exp", 6'b000110);
      idle("br_done");
      chk("br_done_exp", 6'b000000);

      // memory freeze during the shadow cycle
      step("mb_det", 0, 1, 0, '0, '0, 0);
      for (int i = 0; i < 3; i++) begin
         step("mb_hlt", 1, 0, 0, '0, '0, 0);
         chk("mb_hlt_exp", 6'b100000);
      end
      idle("mb_resume");
      chk("mb_resume_exp", 6'b000110);
      idle("mb_done");
      chk("mb_done_exp", 6'b000000);

      // redirect and load-use together
      step("rd_lu", 0, 0, 1, mk(RCC, 6, 5, 1), mk(LOAD, 5, 2, 0), 5);
      chk("rd_lu_exp", 6'b001100);
      step("rd_lu_shadow", 0, 0, 0, mk(RCC, 6, 5, 1), mk(LOAD, 5, 2, 0), 5);
      chk("rd_lu_shadow_exp", 6'b000110);

      // busy timeout: ERR rises on the 15th MWAIT cycle (16th busy cycle)
      for (int i = 1; i <= 20; i++) begin
         step("to_busy", 1, 0, 0, '0, '0, 0);
         if (i == 15) chk("to_before", 6'b100000);
         if (i == 16) chk("to_rise", 6'b100001);
      end
      idle("to_sticky");
      chk("to_sticky_exp", 6'b000001);
      reset_now("to_clear");
      idle("to_cleared");
      chk("to_cleared_exp", 6'b000000);

      // reset in the middle of a flush window restarts cleanly
      step("rst_det", 0, 1, 0, '0, '0, 0);
      reset_now("rst_mid");
      step("rst_det2", 0, 1, 0, '0, '0, 0);
      chk("rst_det2_exp", 6'b000100);
      idle("rst_redir2");
      chk("rst_redir2_exp", 6'b000110);
      idle("rst_done2");

      // random traffic against the model
      burst = 0;
      for (int n = 0; n < 1500; n++) begin
         bit b;
         b = 0;
         if (burst > 0) begin
            b = 1; burst--;
         end else if ($urandom_range(0, 11) == 0) begin
            burst = $urandom_range(0, 4);
            b = 1;
         end
         iop = ops[$urandom_range(0, 7)];
         rrd = 5'($urandom_range(0, 5));
         step("rand", b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 13) == 0),
              mk(iop, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))),
              mk(($urandom_range(0, 2) == 0) ? ICC : LOAD, rrd, 5'd0, 5'd0), rrd);
      end
      idle("tail");

`ifdef HAZARD_PERF_CNT_EN
      @(negedge CLK);
      #1;
      n_tests++;
      assert (LU_CNT === 32'(m_lu)) else begin
         n_fail++; $error("FAIL lu_cnt observed=%0d expected=%0d", LU_CNT, m_lu);
      end
      n_tests++;
      assert (FLUSH_CNT === 32'(m_flush)) else begin
         n_fail++; $error("FAIL flush_cnt observed=%0d expected=%0d", FLUSH_CNT, m_flush);
      end
      n_tests++;
      assert (HLT_CNT === 32'(m_hlt)) else begin
         n_fail++; $error("FAIL hlt_cnt observed=%0d expected=%0d", HLT_CNT, m_hlt);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
